// File: rtl/sm_window_acc.sv
// sm_window_acc: serial sign-magnitude to two's-complement window accumulator; ports clk/rst, clear, in_valid/in_ready/in_sign/in_mag terms in, out_valid/out_ready/out_sum/out_neg window sum out
module sm_window_acc #(
  parameter int MANT_SIZE   = 10,
  parameter int KERNEL_SIZE = 3,
  parameter int GUARD       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sign,
  input  logic [2*MANT_SIZE-1:0]           in_mag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*MANT_SIZE+GUARD:0]       out_sum,
  output logic                             out_neg
);
  localparam int ACC_W = 2*MANT_SIZE+1+GUARD;
  localparam int N     = KERNEL_SIZE*KERNEL_SIZE;
  localparam int CW    = $clog2(N+1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt, sum_nxt, mag_x, term, total;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               last;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == HOLD;
  assign mag_x     = {{(GUARD+1){1'b0}}, in_mag};
  assign term      = in_sign ? ~mag_x + 1'b1 : mag_x;
  assign total     = acc + term;
  assign last      = cnt == CW'(N-1);
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sum_nxt   = out_sum;
    if (state == ACCUM) begin
      if (clear) begin
        acc_nxt = '0;
        cnt_nxt = '0;
      end else if (in_valid) begin
        acc_nxt = last ? '0 : total;
        cnt_nxt = last ? '0 : cnt + 1'b1;
        if (last) begin
          sum_nxt   = total;
          state_nxt = HOLD;
        end
      end
    end else if (out_ready) begin
      state_nxt = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_neg <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      out_sum <= sum_nxt;
      out_neg <= sum_nxt[ACC_W-1];
    end
  end
endmodule

// File: tb/tb_sm_window_acc.sv
// tb_sm_window_acc: self-checking bench for sm_window_acc against a signed-integer window model
module tb_sm_window_acc;
  localparam int M = 10, K = 3, G = 4, N = K*K, W = 2*M+1+G;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, in_sign = 0, out_ready = 0;
  logic [2*M-1:0] in_mag = '0;
  logic in_ready, out_valid, out_neg;
  logic [W-1:0] out_sum;
  int errors = 0, checks = 0;
  longint m_acc = 0;
  int m_cnt = 0;
  logic [W-1:0] exp_sum = '0;
  sm_window_acc #(.MANT_SIZE(M), .KERNEL_SIZE(K), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_mag(in_mag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_neg(out_neg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_sign = 1'($urandom);
      in_mag = 20'($urandom);
      @(negedge clk);
    end
  endtask
  task automatic send(input bit s, input int unsigned mag);
    bit ok = 0;
    in_sign = s;
    in_mag = mag[2*M-1:0];
    in_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1;
      else @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    in_valid = 0;
    in_sign = 1'($urandom);
    in_mag = 20'($urandom);
    m_acc += s ? -longint'(mag) : longint'(mag);
    m_cnt++;
    if (m_cnt == N) begin
      exp_sum = m_acc[W-1:0];
      m_acc = 0;
      m_cnt = 0;
      chk("done_valid", 32'(out_valid), 32'd1);
      chk("done_sum", 32'(out_sum), 32'(exp_sum));
      chk("done_neg", 32'(out_neg), 32'(exp_sum[W-1]));
      chk("done_in_ready", 32'(in_ready), 32'd0);
    end else if ($urandom_range(0, 3) == 0) begin
      chk("partial_valid", 32'(out_valid), 32'd0);
    end
  endtask
  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      in_sign = 1'($urandom);
      in_mag = 20'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(out_sum), 32'(exp_sum));
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask
  task automatic pulse_rst();
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_acc = 0;
    m_cnt = 0;
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_neg", 32'(out_neg), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1;
    for (int i = 1; i <= 9; i++) send(0, i);
    chk("sum45", 32'(out_sum), 32'd45);
    consume(0);
    send(0, 100); send(1, 300); send(0, 50); send(1, 7); send(0, 0);
    send(0, 2); send(1, 1); send(0, 1); send(1, 45);
    chk("sum_m200", 32'(out_sum), 32'h1FFFF38);
    chk("neg_m200", 32'(out_neg), 32'd1);
    consume(0);
    for (int i = 0; i < 9; i++) send(1, 20'hFFFFF);
    chk("max_neg", 32'(out_sum), 32'h1700009);
    consume(0);
    for (int i = 0; i < 9; i++) send(0, 20'hFFFFF);
    chk("max_pos", 32'(out_sum), 32'd9437175);
    consume(0);
    for (int i = 0; i < 9; i++) send(1, 0);
    chk("neg_zero", 32'(out_sum), 32'd0);
    consume(0);
    for (int i = 1; i <= 9; i++) send(i[0], 1000 * i);
    consume(5);
    for (int i = 0; i < 4; i++) send(0, 10);
    clear = 1;
    in_valid = 1;
    in_sign = 0;
    in_mag = 10;
    @(negedge clk);
    clear = 0;
    in_valid = 0;
    m_acc = 0;
    m_cnt = 0;
    for (int i = 0; i < 9; i++) send(0, 1);
    chk("after_clear", 32'(out_sum), 32'd9);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clear_hold_valid", 32'(out_valid), 32'd1);
    chk("clear_hold_sum", 32'(out_sum), 32'd9);
    consume(1);
    for (int i = 0; i < 6; i++) send(0, 77);
    pulse_rst();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 9; i++) send(1, 2);
    chk("sum_m18", 32'(out_sum), 32'h1FFFFEE);
    pulse_rst();
    chk("holdrst_valid", 32'(out_valid), 32'd0);
    chk("holdrst_sum", 32'(out_sum), 32'd0);
    for (int i = 0; i < 9; i++) begin
      idle($urandom_range(0, 3));
      send(1, 2);
    end
    chk("gaps_m18", 32'(out_sum), 32'h1FFFFEE);
    consume(2);
    for (int w = 0; w < 30; w++) begin
      for (int i = 0; i < N; i++) begin
        idle($urandom_range(0, 2));
        send(1'($urandom), $urandom_range(0, 20'hFFFFF));
      end
      consume($urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
